pipeline_id_ex: RTL and testbench
=================================

Name: pipeline_id_ex

Overview:
- ID/EX pipeline register of the 5-stage RISC-V pipeline, directly downstream of the instruction-decode stage.
- Captures the decode stage's register operands, immediate, addresses and control bundle every cycle for the execute stage.
- Contains the load-use hazard detector: it stalls PC and IF/ID and injects a bubble when needed.
- Applies flush on a taken branch or jump, and keeps a bubble/flush event counter for debug.

Parameters:
- XLEN, 32, datapath width of PC, operands and immediate.
- CNT_W, 16, width of the bubble and flush event counters.

Ports:
- clk_IDEX  in  1  pipeline clock; all state updates on rising edge.
- rst_IDEX  in  1  synchronous, active-low reset.
- en_IDEX  in  1  global pipeline enable; 0 = hold everything (memory wait).
- flush_IDEX  in  1  taken branch or jump resolved in EX; kill the instruction entering EX.
- valid_in_IDEX  in  1  the ID-stage instruction is real (not a bubble).
- PC_in_IDEX  in  XLEN  PC of the ID-stage instruction.
- Rs1_data_in / Rs2_data_in  in  XLEN  register-file read data.
- Rs1_addr_in / Rs2_addr_in  in  5  source register addresses.
- Rs1_used_in / Rs2_used_in  in  1  the instruction really reads Rs1 / Rs2.
- Imm_in  in  XLEN  generated immediate.
- Rd_addr_in  in  5  destination register.
- ALUSrc_B_in  in  1  control input.
- MemtoReg_in  in  2  control input.
- Jump_in  in  2  control input.
- Branch_in  in  1  control input.
- BranchN_in  in  1  control input.
- RegWrite_in  in  1  control input.
- MemRW_in  in  1  control input.
- ALU_Control_in  in  4  control input.
- Each input above has a registered *_out counterpart of identical width.
- valid_out_IDEX  out  1  registered valid.
- stall_IDEX  out  1  combinational; freeze PC and IF/ID.
- bubble_cnt  out  CNT_W  load-use bubbles inserted.
- flush_cnt  out  CNT_W  flushes applied.

Behaviour:
- Reset (rst_IDEX=0 at a rising edge):
  - All *_out, valid_out_IDEX and both counters become 0.
  - stall_IDEX is forced 0 during reset.
- Load-use detection, combinational from the registered EX contents and the current ID inputs:
  - load_ex = valid_out_IDEX & RegWrite_out & (MemtoReg_out == MEM2REG_LOAD) & (Rd_addr_out != 0).
  - hazard = valid_in_IDEX & load_ex & ((Rs1_used_in & Rs1_addr_in == Rd_addr_out) | (Rs2_used_in & Rs2_addr_in == Rd_addr_out)).
  - stall_IDEX = hazard & ~flush_IDEX. A flush kills the ID instruction anyway, so no stall is needed.
- Register update priority at each edge (highest first):
  1. Reset: as above.
  2. flush_IDEX=1, regardless of en_IDEX: load a bubble; flush_cnt += 1.
  3. en_IDEX=0: hold all registers; counters unchanged.
  4. hazard=1: load a bubble; bubble_cnt += 1. The ID instruction is re-presented next cycle because stall_IDEX froze IF/ID.
  5. Otherwise: capture all inputs; valid_out = valid_in_IDEX.
- Bubble definition:
  - valid_out=0; RegWrite, MemRW, Branch, BranchN = 0; Jump = 2'b00.
  - MemtoReg = 2'b00; ALUSrc_B = 0; ALU_Control = ALU_ADD.
  - Rd, Rs1 and Rs2 addresses = 0; data, immediate and PC fields = 0.
- Latency: exactly 1 cycle from input to *_out. Load-use costs exactly 1 bubble.
- Counters wrap modulo 2^CNT_W. No saturation.
- Rd_addr_out==0 never raises a hazard (x0).
- An ID instruction with valid_in=0 never stalls. It is passed through as valid_out=0 with its control fields unmodified. Downstream gates side effects with valid_out.
- Flush and hazard in the same cycle: flush wins; only flush_cnt increments.
- Reset deasserted mid-stream: the first post-reset edge captures normally; there is no hazard because EX is invalid.

Decomposition:
- Shared package pipeline_pkg holds:
  - MEM2REG_ALU=2'b00, MEM2REG_LOAD=2'b01, MEM2REG_PC4=2'b10.
  - ALU_ADD=4'b0010.
  - Jump encodings.
  - A packed control-bundle typedef, also used by the EX/MEM register.
- One sub-module, hazard_detect_ld, holds the combinational hazard/stall logic. The register and counters stay in the top module.

Test Plan:
- Normal capture: en=1, add x3,x1,x2 with PC=0x100, Rs1=5, Rs2=7 → next edge PC_out=0x100, Rs1_data_out=5, RegWrite_out=1, valid_out=1, stall=0.
- Load-use: EX holds lw x5 (RegWrite=1, MemtoReg=01, Rd=5); ID holds add x6,x5,x1 with Rs1_used=1 → stall=1. Next edge is a bubble (valid_out=0, RegWrite_out=0) and bubble_cnt=1. The following edge captures the add.
- No false hazard:
  - Same lw with ID sw x5 but Rs2_used=0 → stall=0.
  - lw x0 ahead of a reader of x0 → stall=0.
- Flush vs hazard: load-use condition present with flush_IDEX=1 → stall=0; bubble loaded; flush_cnt=1, bubble_cnt unchanged.
- Hold: en_IDEX=0 for 3 cycles with changing inputs → all outputs constant; counters constant. flush with en=0 still clears valid_out.
- Reset mid-operation: valid pipeline, then rst_IDEX=0 for one edge → all outputs and counters 0; rst high next cycle resumes capture. Counters wrap at 0xFFFF→0x0000 with CNT_W=16.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared encodings and the control bundle carried down the ID/EX and EX/MEM registers.
package pipeline_pkg;

    localparam logic [1:0] MEM2REG_ALU  = 2'b00;
    localparam logic [1:0] MEM2REG_LOAD = 2'b01;
    localparam logic [1:0] MEM2REG_PC4  = 2'b10;

    localparam logic [1:0] JUMP_NONE = 2'b00;
    localparam logic [1:0] JUMP_JAL  = 2'b01;
    localparam logic [1:0] JUMP_JALR = 2'b10;

    localparam logic [3:0] ALU_ADD = 4'b0010;

    typedef struct packed {
        logic       alusrc_b;
        logic [1:0] memtoreg;
        logic [1:0] jump;
        logic       branch;
        logic       branchn;
        logic       regwrite;
        logic       memrw;
        logic [3:0] alu_control;
    } ctrl_t;

    // Control fields of an injected bubble: no side effects, ALU idles on ADD.
    localparam ctrl_t CTRL_BUBBLE = '{
        alusrc_b:    1'b0,
        memtoreg:    MEM2REG_ALU,
        jump:        JUMP_NONE,
        branch:      1'b0,
        branchn:     1'b0,
        regwrite:    1'b0,
        memrw:       1'b0,
        alu_control: ALU_ADD
    };

endpackage

// File: rtl/hazard_detect_ld.sv
// Load-use hazard detector: the instruction in EX is a load whose rd is read by the ID instruction.
module hazard_detect_ld
    import pipeline_pkg::*;
(
    input  logic       active,
    input  logic       flush,
    input  logic       valid_id,
    input  logic [4:0] rs1_addr,
    input  logic [4:0] rs2_addr,
    input  logic       rs1_used,
    input  logic       rs2_used,
    input  logic       valid_ex,
    input  logic       regwrite_ex,
    input  logic [1:0] memtoreg_ex,
    input  logic [4:0] rd_ex,
    output logic       hazard,
    output logic       stall
);

    logic load_ex;
    logic rs1_hit;
    logic rs2_hit;

    assign load_ex = valid_ex & regwrite_ex & (memtoreg_ex == MEM2REG_LOAD) & (rd_ex != 5'd0);
    assign rs1_hit = rs1_used & (rs1_addr == rd_ex);
    assign rs2_hit = rs2_used & (rs2_addr == rd_ex);
    assign hazard  = valid_id & load_ex & (rs1_hit | rs2_hit);

    // A flush kills the ID instruction anyway, so freezing IF/ID would be wasted.
    assign stall   = active & hazard & ~flush;

endmodule

// File: rtl/pipeline_id_ex.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and debug event counters.
module pipeline_id_ex
    import pipeline_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_IDEX,
    input  logic             rst_IDEX,
    input  logic             en_IDEX,
    input  logic             flush_IDEX,
    input  logic             valid_in_IDEX,
    input  logic [XLEN-1:0]  PC_in_IDEX,
    input  logic [XLEN-1:0]  Rs1_data_in,
    input  logic [XLEN-1:0]  Rs2_data_in,
    input  logic [4:0]       Rs1_addr_in,
    input  logic [4:0]       Rs2_addr_in,
    input  logic             Rs1_used_in,
    input  logic             Rs2_used_in,
    input  logic [XLEN-1:0]  Imm_in,
    input  logic [4:0]       Rd_addr_in,
    input  logic             ALUSrc_B_in,
    input  logic [1:0]       MemtoReg_in,
    input  logic [1:0]       Jump_in,
    input  logic             Branch_in,
    input  logic             BranchN_in,
    input  logic             RegWrite_in,
    input  logic             MemRW_in,
    input  logic [3:0]       ALU_Control_in,
    output logic             valid_out_IDEX,
    output logic [XLEN-1:0]  PC_out_IDEX,
    output logic [XLEN-1:0]  Rs1_data_out,
    output logic [XLEN-1:0]  Rs2_data_out,
    output logic [4:0]       Rs1_addr_out,
    output logic [4:0]       Rs2_addr_out,
    output logic             Rs1_used_out,
    output logic             Rs2_used_out,
    output logic [XLEN-1:0]  Imm_out,
    output logic [4:0]       Rd_addr_out,
    output logic             ALUSrc_B_out,
    output logic [1:0]       MemtoReg_out,
    output logic [1:0]       Jump_out,
    output logic             Branch_out,
    output logic             BranchN_out,
    output logic             RegWrite_out,
    output logic             MemRW_out,
    output logic [3:0]       ALU_Control_out,
    output logic             stall_IDEX,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [4:0]      rd_addr;
        logic            rs1_used;
        logic            rs2_used;
        ctrl_t           ctrl;
    } idex_t;

    idex_t d;
    idex_t q;
    idex_t bubble;
    logic  hazard;

    always_comb begin
        d.valid    = valid_in_IDEX;
        d.pc       = PC_in_IDEX;
        d.rs1_data = Rs1_data_in;
        d.rs2_data = Rs2_data_in;
        d.imm      = Imm_in;
        d.rs1_addr = Rs1_addr_in;
        d.rs2_addr = Rs2_addr_in;
        d.rd_addr  = Rd_addr_in;
        d.rs1_used = Rs1_used_in;
        d.rs2_used = Rs2_used_in;
        d.ctrl     = '{alusrc_b: ALUSrc_B_in, memtoreg: MemtoReg_in, jump: Jump_in,
                       branch: Branch_in, branchn: BranchN_in, regwrite: RegWrite_in,
                       memrw: MemRW_in, alu_control: ALU_Control_in};
    end

    always_comb begin
        bubble      = '0;
        bubble.ctrl = CTRL_BUBBLE;
    end

    hazard_detect_ld u_hazard (
        .active      (rst_IDEX),
        .flush       (flush_IDEX),
        .valid_id    (valid_in_IDEX),
        .rs1_addr    (Rs1_addr_in),
        .rs2_addr    (Rs2_addr_in),
        .rs1_used    (Rs1_used_in),
        .rs2_used    (Rs2_used_in),
        .valid_ex    (q.valid),
        .regwrite_ex (q.ctrl.regwrite),
        .memtoreg_ex (q.ctrl.memtoreg),
        .rd_ex       (q.rd_addr),
        .hazard      (hazard),
        .stall       (stall_IDEX)
    );

    // Flush overrides the global enable; a hazard only matters when the pipe advances.
    always_ff @(posedge clk_IDEX) begin
        if (!rst_IDEX) begin
            q          <= '0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else if (flush_IDEX) begin
            q         <= bubble;
            flush_cnt <= flush_cnt + CNT_W'(1);
        end else if (en_IDEX) begin
            if (hazard) begin
                q          <= bubble;
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end else begin
                q <= d;
            end
        end
    end

    assign valid_out_IDEX  = q.valid;
    assign PC_out_IDEX     = q.pc;
    assign Rs1_data_out    = q.rs1_data;
    assign Rs2_data_out    = q.rs2_data;
    assign Imm_out         = q.imm;
    assign Rs1_addr_out    = q.rs1_addr;
    assign Rs2_addr_out    = q.rs2_addr;
    assign Rd_addr_out     = q.rd_addr;
    assign Rs1_used_out    = q.rs1_used;
    assign Rs2_used_out    = q.rs2_used;
    assign ALUSrc_B_out    = q.ctrl.alusrc_b;
    assign MemtoReg_out    = q.ctrl.memtoreg;
    assign Jump_out        = q.ctrl.jump;
    assign Branch_out      = q.ctrl.branch;
    assign BranchN_out     = q.ctrl.branchn;
    assign RegWrite_out    = q.ctrl.regwrite;
    assign MemRW_out       = q.ctrl.memrw;
    assign ALU_Control_out = q.ctrl.alu_control;

endmodule

// File: tb/tb_pipeline_id_ex.sv
// Random and directed stimulus for pipeline_id_ex against a cycle-level reference of the stage rules.
module tb_pipeline_id_ex;

    typedef struct {
        logic        valid;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1a, rs2a, rd;
        logic        rs1u, rs2u, alusrc, br, brn, rw, mrw;
        logic [1:0]  m2r, jump;
        logic [3:0]  aluc;
    } st_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b1;
    logic flush = 1'b0;
    st_t  in_s;
    st_t  exp_s;
    logic [15:0] exp_bcnt, exp_fcnt;
    int checks = 0;
    int failures = 0;

    logic        valid_out, rs1u_o, rs2u_o, alusrc_o, br_o, brn_o, rw_o, mrw_o, stall;
    logic [31:0] pc_o, rs1d_o, rs2d_o, imm_o;
    logic [4:0]  rs1a_o, rs2a_o, rd_o;
    logic [1:0]  m2r_o, jump_o;
    logic [3:0]  aluc_o;
    logic [15:0] bcnt, fcnt;

    always #5 clk = ~clk;

    pipeline_id_ex #(.XLEN(32), .CNT_W(16)) dut (
        .clk_IDEX(clk), .rst_IDEX(rst), .en_IDEX(en), .flush_IDEX(flush),
        .valid_in_IDEX(in_s.valid), .PC_in_IDEX(in_s.pc),
        .Rs1_data_in(in_s.rs1d), .Rs2_data_in(in_s.rs2d),
        .Rs1_addr_in(in_s.rs1a), .Rs2_addr_in(in_s.rs2a),
        .Rs1_used_in(in_s.rs1u), .Rs2_used_in(in_s.rs2u),
        .Imm_in(in_s.imm), .Rd_addr_in(in_s.rd),
        .ALUSrc_B_in(in_s.alusrc), .MemtoReg_in(in_s.m2r), .Jump_in(in_s.jump),
        .Branch_in(in_s.br), .BranchN_in(in_s.brn), .RegWrite_in(in_s.rw),
        .MemRW_in(in_s.mrw), .ALU_Control_in(in_s.aluc),
        .valid_out_IDEX(valid_out), .PC_out_IDEX(pc_o),
        .Rs1_data_out(rs1d_o), .Rs2_data_out(rs2d_o),
        .Rs1_addr_out(rs1a_o), .Rs2_addr_out(rs2a_o),
        .Rs1_used_out(rs1u_o), .Rs2_used_out(rs2u_o),
        .Imm_out(imm_o), .Rd_addr_out(rd_o),
        .ALUSrc_B_out(alusrc_o), .MemtoReg_out(m2r_o), .Jump_out(jump_o),
        .Branch_out(br_o), .BranchN_out(brn_o), .RegWrite_out(rw_o),
        .MemRW_out(mrw_o), .ALU_Control_out(aluc_o),
        .stall_IDEX(stall), .bubble_cnt(bcnt), .flush_cnt(fcnt)
    );

    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [191:0] pack(input st_t s);
        return {s.valid, s.pc, s.rs1d, s.rs2d, s.imm, s.rs1a, s.rs2a, s.rd, s.rs1u, s.rs2u,
                s.alusrc, s.m2r, s.jump, s.br, s.brn, s.rw, s.mrw, s.aluc};
    endfunction

    function automatic st_t zero_st();
        st_t s;
        s = '{valid: 0, pc: 0, rs1d: 0, rs2d: 0, imm: 0, rs1a: 0, rs2a: 0, rd: 0, rs1u: 0,
              rs2u: 0, alusrc: 0, br: 0, brn: 0, rw: 0, mrw: 0, m2r: 0, jump: 0, aluc: 0};
        return s;
    endfunction

    // A load in EX (valid, writes a non-x0 register from memory) that the ID instruction reads.
    function automatic bit model_hazard();
        bit ex_is_load;
        ex_is_load = exp_s.valid && exp_s.rw && exp_s.m2r == 2'b01 && exp_s.rd != 0;
        return in_s.valid && ex_is_load &&
               ((in_s.rs1u && in_s.rs1a == exp_s.rd) || (in_s.rs2u && in_s.rs2a == exp_s.rd));
    endfunction

    function automatic logic [191:0] dut_vec();
        return {valid_out, pc_o, rs1d_o, rs2d_o, imm_o, rs1a_o, rs2a_o, rd_o, rs1u_o, rs2u_o,
                alusrc_o, m2r_o, jump_o, br_o, brn_o, rw_o, mrw_o, aluc_o};
    endfunction

    // Check stall before the edge, advance the reference, check registered state after it.
    task automatic step(input bit do_chk);
        bit hz;
        st_t bub;
        #1;
        hz = model_hazard();
        if (do_chk) chk("stall", 192'(stall), 192'(rst && hz && !flush));
        @(posedge clk);
        bub = zero_st();
        bub.aluc = 4'b0010;
        if (!rst) begin
            exp_s = zero_st(); exp_bcnt = 0; exp_fcnt = 0;
        end else if (flush) begin
            exp_s = bub; exp_fcnt = exp_fcnt + 16'd1;
        end else if (en) begin
            if (hz) begin exp_s = bub; exp_bcnt = exp_bcnt + 16'd1; end
            else exp_s = in_s;
        end
        #1;
        if (do_chk) begin
            chk("regs", dut_vec(), pack(exp_s));
            chk("bubble_cnt", 192'(bcnt), 192'(exp_bcnt));
            chk("flush_cnt", 192'(fcnt), 192'(exp_fcnt));
        end
    endtask

    function automatic st_t instr(input logic [4:0] rd, input logic [4:0] a1, input bit u1,
                                  input logic [4:0] a2, input bit u2, input logic [1:0] m2r);
        st_t s;
        s = zero_st();
        s.valid = 1; s.pc = 32'h100; s.rs1d = 5; s.rs2d = 7; s.imm = 32'h10;
        s.rd = rd; s.rs1a = a1; s.rs1u = u1; s.rs2a = a2; s.rs2u = u2;
        s.rw = 1; s.m2r = m2r; s.aluc = 4'b0010;
        return s;
    endfunction

    function automatic st_t rand_st();
        st_t s;
        s.valid = ($urandom_range(0, 9) < 8); s.pc = $urandom; s.rs1d = $urandom;
        s.rs2d = $urandom; s.imm = $urandom;
        s.rs1a = 5'($urandom_range(0, 3)); s.rs2a = 5'($urandom_range(0, 3));
        s.rd = 5'($urandom_range(0, 3));
        s.rs1u = 1'($urandom); s.rs2u = 1'($urandom); s.alusrc = 1'($urandom);
        s.br = 1'($urandom); s.brn = 1'($urandom); s.rw = 1'($urandom); s.mrw = 1'($urandom);
        s.m2r = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'($urandom_range(0, 2));
        s.jump = 2'($urandom_range(0, 2)); s.aluc = 4'($urandom);
        return s;
    endfunction

    initial begin
        in_s = zero_st(); exp_s = zero_st(); exp_bcnt = 0; exp_fcnt = 0;

        // Reset state, with a load-use pattern present to show stall is held low.
        in_s = instr(6, 5, 1, 1, 1, 2'b00);
        step(1);
        chk("reset_valid", 192'(valid_out), 192'(0));
        rst = 1;

        // Normal capture: add x3,x1,x2 at PC 0x100.
        in_s = instr(3, 1, 1, 2, 1, 2'b00);
        step(1);
        chk("cap_pc", 192'(pc_o), 192'(32'h100));
        chk("cap_rs1", 192'(rs1d_o), 192'(5));
        chk("cap_rw_valid", 192'({rw_o, valid_out}), 192'(2'b11));

        // Load-use: lw x5 then add x6,x5,x1 -> one bubble, then the add.
        in_s = instr(5, 1, 1, 0, 0, 2'b01);
        step(1);
        in_s = instr(6, 5, 1, 1, 1, 2'b00);
        #1 chk("lu_stall", 192'(stall), 192'(1));
        step(1);
        chk("lu_bubble", 192'({valid_out, rw_o, aluc_o}), 192'({2'b00, 4'b0010}));
        chk("lu_bcnt", 192'(bcnt), 192'(1));
        step(1);
        chk("lu_resume", 192'({valid_out, rd_o}), 192'({1'b1, 5'd6}));

        // No false hazards: unused rs2, and a load to x0.
        in_s = instr(5, 1, 1, 0, 0, 2'b01);
        step(1);
        in_s = instr(0, 1, 1, 5, 0, 2'b00);
        #1 chk("nf_rs2_unused", 192'(stall), 192'(0));
        step(1);
        in_s = instr(0, 1, 1, 0, 0, 2'b01);
        step(1);
        in_s = instr(7, 0, 1, 0, 1, 2'b00);
        #1 chk("nf_x0", 192'(stall), 192'(0));
        step(1);

        // Flush beats hazard.
        in_s = instr(5, 1, 1, 0, 0, 2'b01);
        step(1);
        in_s = instr(6, 5, 1, 1, 1, 2'b00);
        flush = 1;
        #1 chk("fh_stall", 192'(stall), 192'(0));
        step(1);
        flush = 0;
        chk("fh_cnts", 192'({valid_out, bcnt, fcnt}), 192'({1'b0, 16'd1, 16'd1}));

        // Hold for 3 cycles with changing inputs, then flush while disabled.
        in_s = instr(9, 2, 1, 3, 1, 2'b00);
        step(1);
        en = 0;
        repeat (3) begin in_s = rand_st(); step(1); end
        chk("hold_rd", 192'({valid_out, rd_o}), 192'({1'b1, 5'd9}));
        flush = 1;
        step(1);
        chk("flush_en0", 192'(valid_out), 192'(0));
        flush = 0; en = 1;

        // Reset in the middle of traffic, then resume.
        in_s = instr(4, 1, 1, 2, 1, 2'b00);
        step(1);
        rst = 0;
        step(1);
        chk("midrst", 192'({valid_out, bcnt, fcnt}), 192'(0));
        rst = 1;
        step(1);
        chk("post_rst", 192'({valid_out, rd_o}), 192'({1'b1, 5'd4}));

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            in_s  = rand_st();
            en    = ($urandom_range(0, 99) < 85);
            flush = ($urandom_range(0, 99) < 10);
            rst   = ($urandom_range(0, 99) >= 2);
            step(1);
        end

        // Flush counter wrap.
        rst = 0; flush = 0; en = 1;
        step(1);
        rst = 1; flush = 1;
        for (int i = 0; i < 65534; i++) step(0);
        step(1);
        chk("wrap_ffff", 192'(fcnt), 192'(16'hFFFF));
        step(1);
        chk("wrap_zero", 192'(fcnt), 192'(0));
        flush = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
